// File: rtl/tdm_frame_serializer.sv
// Time-division serializer: snapshots N_SIGNALS words and streams them N_PINS bits per beat over valid/ready.
// Optional TDM_PARITY_EN adds an out_parity port carrying the even parity of out_data.
module tdm_frame_serializer #(
  parameter int unsigned N_SIGNALS  = 4,
  parameter int unsigned SIG_WIDTH  = 16,
  parameter int unsigned N_PINS     = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  input  logic                          cont_mode,
  input  logic [SIG_WIDTH*N_SIGNALS-1:0] signals,
  output logic [N_PINS-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_sync,
  output logic                          frame_last,
  output logic                          busy,
`ifdef TDM_PARITY_EN
  output logic                          out_parity,
`endif
  output logic                          done
);

  localparam int unsigned TOTAL_W  = SIG_WIDTH * N_SIGNALS;
  localparam int unsigned BEATS    = TOTAL_W / N_PINS;
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     beat_cnt, beat_n;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic [TOTAL_W-1:0]   shadow, shadow_n;
  logic [N_PINS-1:0]    data_n;
  logic                 valid_n;
  logic                 done_n;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, counters and snapshot control
  always_comb begin
    state_n  = state;
    beat_n   = beat_cnt;
    gap_n    = gap_cnt;
    shadow_n = shadow;
    done_n   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      beat_n  = '0;
      gap_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow_n = signals;
            beat_n   = '0;
            state_n  = SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_n = '0;
              if (!cont_mode) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end else if (GAP_CYCLES == 0) begin
                shadow_n = signals;
              end else begin
                state_n = GAP;
                gap_n   = '0;
              end
            end else begin
              beat_n = beat_cnt + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            shadow_n = signals;
            gap_n    = '0;
            state_n  = SEND;
          end else begin
            gap_n = gap_cnt + GAP_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output beat is pre-computed from the next snapshot/counter so every output is a flop
  always_comb begin
    valid_n = (state_n == SEND);
    data_n  = valid_n ? N_PINS'(shadow_n >> (int'(beat_n) * N_PINS)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      shadow     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_sync <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      beat_cnt   <= beat_n;
      gap_cnt    <= gap_n;
      shadow     <= shadow_n;
      out_data   <= data_n;
      out_valid  <= valid_n;
      frame_sync <= valid_n && (beat_n == '0);
      frame_last <= valid_n && (beat_n == LAST_BEAT);
      busy       <= (state_n != IDLE);
      done       <= done_n;
    end
  end

`ifdef TDM_PARITY_EN
  // data_n is zero outside SEND, so parity is zero in IDLE/GAP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_parity <= 1'b0;
    else       out_parity <= ^data_n;
  end
`endif

endmodule

// File: tb/tb_tdm_frame_serializer.sv
// Self-checking bench for tdm_frame_serializer (4x16 bits, 4 pins, GAP_CYCLES=2).
// Expected beats come from a nibble-extraction model of the snapshotted 64-bit frame.
module tb_tdm_frame_serializer;

  localparam int unsigned NS    = 4;
  localparam int unsigned SW    = 16;
  localparam int unsigned NP    = 4;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned BEATS = NS * SW / NP;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        cont_mode;
  logic [63:0] signals;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        frame_sync;
  logic        frame_last;
  logic        busy;
  logic        done;
`ifdef TDM_PARITY_EN
  logic        out_parity;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdm_frame_serializer #(
    .N_SIGNALS (NS),
    .SIG_WIDTH (SW),
    .N_PINS    (NP),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .cont_mode (cont_mode),
    .signals   (signals),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_sync(frame_sync),
    .frame_last(frame_last),
    .busy      (busy),
`ifdef TDM_PARITY_EN
    .out_parity(out_parity),
`endif
    .done      (done)
  );

  function automatic logic [3:0] beat_of(input logic [63:0] snap, input int k);
    return 4'(snap >> (4 * k));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [63:0] snap);
    signals = snap;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: ready low 3 cycles at beat 5; mode 2: random ready and stray starts.
  // Returns early (beat observed, not accepted) when abort_at is reached.
  task automatic recv_frame(input logic [63:0] snap, input int mode, input int abort_at);
    int idx = 0;
    int cycles = 0;
    int stalls = 0;
    int hold5 = 0;
    while (idx < int'(BEATS) && cycles < 200) begin
      check($sformatf("valid_b%0d", idx), 64'(out_valid), 64'(1));
      check($sformatf("data_b%0d", idx), 64'(out_data), 64'(beat_of(snap, idx)));
      check($sformatf("sync_b%0d", idx), 64'(frame_sync), 64'(idx == 0));
      check($sformatf("last_b%0d", idx), 64'(frame_last), 64'(idx == int'(BEATS) - 1));
`ifdef TDM_PARITY_EN
      check($sformatf("parity_b%0d", idx), 64'(out_parity), 64'(^beat_of(snap, idx)));
`endif
      if (idx == abort_at) return;
      if (idx == 5) hold5++;
      case (mode)
        1: begin
          if (idx == 5 && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
          end else out_ready = 1'b1;
        end
        2: begin
          out_ready = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 3) == 0);
        end
        default: out_ready = 1'b1;
      endcase
      if (out_ready) idx++;
      tick();
      cycles++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("frame_beats", 64'(idx), 64'(BEATS));
    if (mode == 1) check("stall_hold5", 64'(hold5), 64'(4));
  endtask

  task automatic check_done;
    check("done_pulse", 64'(done), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    check("valid_after", 64'(out_valid), 64'(0));
    tick();
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    logic [63:0] sa;
    logic [63:0] sb;
    int gap;
    reset = 1'b1; enable = 1'b1; start = 1'b0; cont_mode = 1'b0;
    out_ready = 1'b1; signals = '0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sync", 64'(frame_sync), 64'(0));
    reset = 1'b0;
    tick();

    // Directed reference frame, then the same frame with a 3-cycle stall
    start_frame(64'h4444_3333_2222_1111);
    recv_frame(64'h4444_3333_2222_1111, 0, -1);
    check_done();
    start_frame(64'h4444_3333_2222_1111);
    recv_frame(64'h4444_3333_2222_1111, 1, -1);
    check_done();

    // Parity-relevant nibbles 7 and 3 plus random frames with backpressure
    start_frame(64'h3737_0000_FFFF_1248);
    recv_frame(64'h3737_0000_FFFF_1248, 2, -1);
    check_done();
    for (int r = 0; r < 6; r++) begin
      sa = {$urandom, $urandom};
      start_frame(sa);
      signals = {$urandom, $urandom};
      recv_frame(sa, 2, -1);
      check_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    // Continuous mode: frame A, exactly GAPC idle cycles, frame B from new snapshot
    sa = {$urandom, $urandom};
    sb = {$urandom, $urandom};
    cont_mode = 1'b1;
    start_frame(sa);
    signals = sb;
    recv_frame(sa, 0, -1);
    gap = 0;
    while (!out_valid && gap < 10) begin
      check("gap_no_done", 64'(done), 64'(0));
      check("gap_busy", 64'(busy), 64'(1));
      gap++;
      tick();
    end
    check("gap_len", 64'(gap), 64'(GAPC));
    cont_mode = 1'b0;
    signals = {$urandom, $urandom};
    recv_frame(sb, 2, -1);
    check_done();

    // Enable dropped at beat 7 aborts without done; restart sends from beat 0
    sa = {$urandom, $urandom};
    start_frame(sa);
    recv_frame(sa, 0, 7);
    enable = 1'b0;
    tick();
    check("en_valid", 64'(out_valid), 64'(0));
    check("en_busy", 64'(busy), 64'(0));
    check("en_done", 64'(done), 64'(0));
    check("en_data", 64'(out_data), 64'(0));
    tick();
    check("en_done2", 64'(done), 64'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("en_start_blocked", 64'(busy), 64'(0));
    enable = 1'b1;
    start_frame(sa);
    recv_frame(sa, 0, -1);
    check_done();

    // Asynchronous reset at beat 10 clears outputs before any clock edge
    start_frame(64'h4444_3333_2222_1111);
    recv_frame(64'h4444_3333_2222_1111, 0, 10);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_data", 64'(out_data), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_last", 64'(frame_last), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    check("arst_idle", 64'(busy), 64'(0));
    sa = {$urandom, $urandom};
    start_frame(sa);
    recv_frame(sa, 2, -1);
    check_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
